uart_rx: RTL and testbench

- Serial UART receiver that sits directly upstream of the receive FIFO.
- Oversamples the asynchronous `Rx_Serial` line, frames start/data/(parity)/stop bits and presents each good character on `Rx_Data` with a one-cycle `Data_Rdy` strobe.
- `Rx_Data` and `Data_Rdy` connect straight to the FIFO's write side.
- Reports framing and parity faults as one-cycle pulses; bad characters are never written downstream.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with framing/parity fault pulses.
//            Optional parity bit enabled by defining UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS       = 8,
    parameter int OVERSAMPLE      = 16,
    parameter int CLKS_PER_SAMPLE = 27,
    parameter bit PARITY_ODD      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_Serial,
    input  logic                 BIST_Mode,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Framing_Error,
    output logic                 Parity_Error,
    output logic                 Rx_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]   HALF_LAST = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY     = 3'd5;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic                 sync1;
    logic                 rx_s;
    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [CNT_W-1:0]     clk_cnt;
    logic [S_W-1:0]       s_cnt;
    logic [S_W-1:0]       s_target;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tick;
    logic                 sample_now;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`else
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD;
    assign Parity_Error      = 1'b0;
`endif

    // The start bit is sampled at its midpoint; every later bit one full period on.
    assign tick       = (clk_cnt == CNT_LAST);
    assign s_target   = (state == START) ? HALF_LAST : S_LAST;
    assign sample_now = tick && (s_cnt == s_target);

    always_comb begin
        state_next = state;
        if (BIST_Mode) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      if (!rx_s) state_next = START;
                START:     if (sample_now) state_next = rx_s ? IDLE : DATA;
                DATA:      if (sample_now && bit_idx == LAST_IDX) state_next = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
                PARITY:    if (sample_now) state_next = STOP;
`endif
                // A low stop bit parks in WAIT_IDLE so a break is not re-framed.
                STOP:      if (sample_now) state_next = rx_s ? IDLE : WAIT_IDLE;
                WAIT_IDLE: if (rx_s) state_next = IDLE;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b1;
            rx_s          <= 1'b1;
            state         <= IDLE;
            clk_cnt       <= '0;
            s_cnt         <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            Rx_Data       <= '0;
            Data_Rdy      <= 1'b0;
            Framing_Error <= 1'b0;
            Rx_Busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err    <= 1'b0;
            Parity_Error  <= 1'b0;
`endif
        end else begin
            sync1         <= Rx_Serial;
            rx_s          <= sync1;
            state         <= state_next;
            Rx_Busy       <= (state_next != IDLE);
            Data_Rdy      <= 1'b0;
            Framing_Error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            Parity_Error  <= 1'b0;
`endif
            if (state == IDLE || BIST_Mode) begin
                clk_cnt <= '0;
                s_cnt   <= '0;
            end else begin
                clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
                if (tick) s_cnt <= sample_now ? '0 : s_cnt + 1'b1;
            end

            if (sample_now && !BIST_Mode) begin
                case (state)
                    START: begin
                        bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                        parity_err <= 1'b0;
`endif
                    end
                    DATA: begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: parity_err <= (rx_s != ((^shift_reg) ^ PARITY_ODD));
`endif
                    STOP: begin
                        if (!rx_s) begin
                            Framing_Error <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (parity_err) begin
                            Parity_Error <= 1'b1;
`endif
                        end else begin
                            Rx_Data  <= shift_reg;
                            Data_Rdy <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (64 clk per bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPS      = 4;
    localparam int OV       = 16;
    localparam int BIT_CLKS = CPS * OV;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // two synchroniser edges + detect edge + ticks to the stop sample
    localparam int LAT = 3 + (OV / 2 + OV * (8 + 1 + P)) * CPS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rx_Serial = 1'b1;
    logic       BIST_Mode = 1'b0;
    logic [7:0] Rx_Data;
    logic       Data_Rdy;
    logic       Framing_Error;
    logic       Parity_Error;
    logic       Rx_Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0, fe_cnt = 0, pe_cnt = 0, multi_cnt = 0;
    int last_rdy_cyc = 0, start_cyc = 0;
    int b_rdy, b_fe, b_pe;
    logic [7:0] rx_q[$];

    uart_rx #(
        .DATA_BITS(8), .OVERSAMPLE(OV), .CLKS_PER_SAMPLE(CPS), .PARITY_ODD(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .Rx_Serial(Rx_Serial), .BIST_Mode(BIST_Mode),
        .Rx_Data(Rx_Data), .Data_Rdy(Data_Rdy), .Framing_Error(Framing_Error),
        .Parity_Error(Parity_Error), .Rx_Busy(Rx_Busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (Data_Rdy) begin
            rdy_cnt++;
            rx_q.push_back(Rx_Data);
            last_rdy_cyc = cyc;
        end
        if (Framing_Error) fe_cnt++;
        if (Parity_Error) pe_cnt++;
        if (int'(Data_Rdy) + int'(Framing_Error) + int'(Parity_Error) > 1) multi_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Rx_Serial = b;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored without parity bit");
`endif
        send_bit(stop_val);
    endtask

    task automatic snap();
        b_rdy = rdy_cnt;
        b_fe  = fe_cnt;
        b_pe  = pe_cnt;
    endtask

    task automatic idle(input int n);
        Rx_Serial = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_partial(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        Rx_Serial = d[3];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_data", Rx_Data, 8'h00);
        check_eq("rst_rdy", Data_Rdy, 1'b0);
        check_eq("rst_fe", Framing_Error, 1'b0);
        check_eq("rst_pe", Parity_Error, 1'b0);
        check_eq("rst_busy", Rx_Busy, 1'b0);
        rst = 1'b0;
        idle(20);

        // good frame
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        check_eq("good_rdy", rdy_cnt - b_rdy, 1);
        check_eq("good_data", Rx_Data, 8'hA5);
        check_eq("good_fe", fe_cnt - b_fe, 0);
        check_eq("good_pe", pe_cnt - b_pe, 0);
        check_eq("good_busy", Rx_Busy, 1'b0);
        check_eq("good_latency", last_rdy_cyc - start_cyc, LAT);

        // false start
        snap();
        Rx_Serial = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle(100);
        check_eq("false_rdy", rdy_cnt - b_rdy, 0);
        check_eq("false_fe", fe_cnt - b_fe, 0);
        check_eq("false_busy", Rx_Busy, 1'b0);
        check_eq("false_data", Rx_Data, 8'hA5);

        // framing error followed by a break
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        Rx_Serial = 1'b0;
        repeat (500 - BIT_CLKS) @(posedge clk);
        #1;
        idle(BIT_CLKS);
        check_eq("frame_fe", fe_cnt - b_fe, 1);
        check_eq("frame_rdy", rdy_cnt - b_rdy, 0);
        check_eq("frame_data", Rx_Data, 8'hA5);
        snap();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        check_eq("recover_rdy", rdy_cnt - b_rdy, 1);
        check_eq("recover_data", Rx_Data, 8'h81);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        check_eq("par_ok_rdy", rdy_cnt - b_rdy, 1);
        check_eq("par_ok_data", Rx_Data, 8'h07);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        check_eq("par_bad_pe", pe_cnt - b_pe, 1);
        check_eq("par_bad_rdy", rdy_cnt - b_rdy, 0);
        check_eq("par_bad_data", Rx_Data, 8'h07);
`endif

        // back-to-back with a single stop bit
        snap();
        rx_q.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(4);
        check_eq("b2b_count", rdy_cnt - b_rdy, 3);
        check_eq("b2b_0", rx_q.size() > 0 ? rx_q[0] : 8'hEE, 8'h00);
        check_eq("b2b_1", rx_q.size() > 1 ? rx_q[1] : 8'hEE, 8'hFF);
        check_eq("b2b_2", rx_q.size() > 2 ? rx_q[2] : 8'hEE, 8'h55);

        // abort via BIST_Mode during bit 3
        snap();
        start_partial(8'h5A);
        check_eq("bist_busy_before", Rx_Busy, 1'b1);
        BIST_Mode = 1'b1;
        Rx_Serial = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bist_busy_drop", Rx_Busy, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        BIST_Mode = 1'b0;
        idle(700);
        check_eq("bist_rdy", rdy_cnt - b_rdy, 0);
        check_eq("bist_fe", fe_cnt - b_fe, 0);
        check_eq("bist_data", Rx_Data, 8'h55);

        // abort via reset during bit 3
        start_partial(8'h5A);
        rst = 1'b1;
        Rx_Serial = 1'b1;
        @(posedge clk);
        #1;
        check_eq("arst_data", Rx_Data, 8'h00);
        check_eq("arst_rdy", Data_Rdy, 1'b0);
        check_eq("arst_fe", Framing_Error, 1'b0);
        check_eq("arst_pe", Parity_Error, 1'b0);
        check_eq("arst_busy", Rx_Busy, 1'b0);
        rst = 1'b0;
        idle(20);

        check_eq("exclusive", multi_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
